logic_driver: RTL and testbench

Sequential front end for the 16-bit ALU logic unit. Accepts two 16-bit operands and a 2-bit operation select over a valid/ready stream. Packs them onto the logic unit's 32-bit operand bus and select lines, then captures the packed 32-bit result. Returns the result as two 16-bit beats over a second valid/ready stream, so the logic unit can be driven from a narrow 16-bit datapath.

---
 rtl/logic_driver_if.sv | 20 ++
 rtl/logic_driver.sv | 118 +++++++++++
 tb/tb_logic_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_driver_if.sv
// Operand and result valid/ready streams between a 16-bit datapath and logic_driver.
interface logic_driver_if;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_data;
  logic [1:0]  op_sel;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;

  modport master (
    output op_valid, op_data, op_sel, res_ready,
    input  op_ready, res_valid, res_data
  );

  modport slave (
    input  op_valid, op_data, op_sel, res_ready,
    output op_ready, res_valid, res_data
  );
endinterface

// File: rtl/logic_driver.sv
// Sequential 16-bit front end for the 32-bit packed logic unit: two operand beats in, two result beats out.
// Optional in-line result checker enabled by defining LOGIC_DRIVER_SELF_CHECK_EN.
module logic_driver (
  input  logic           clk,
  input  logic           rst_n,
  logic_driver_if.slave  bus,
  output logic [31:0]    logic_in,
  output logic [1:0]     logic_lines,
  input  logic [31:0]    logic_out,
  output logic [7:0]     txn_count,
  output logic           chk_err
);

  typedef enum logic [2:0] {IDLE, OP2, ISSUE, SEND_HI, SEND_LO} state_e;

  state_e      state_q;
  logic [15:0] op1_q;
  logic [1:0]  sel_q;
  logic [31:0] logic_in_q;
  logic [1:0]  lines_q;
  logic [15:0] res_lo_q;
  logic        op_ready_q;
  logic        res_valid_q;
  logic [15:0] res_data_q;
  logic [7:0]  txn_q;

`ifdef LOGIC_DRIVER_SELF_CHECK_EN
  logic        chk_q;
  logic [31:0] exp_d;
  logic [15:0] a_d;
  logic [15:0] b_d;

  always_comb begin
    a_d = logic_in_q[31:16];
    b_d = logic_in_q[15:0];
    exp_d = '0;
    case (lines_q)
      2'd0:    exp_d = {a_d & b_d, ~(a_d & b_d)};
      2'd1:    exp_d = {a_d | b_d, ~(a_d | b_d)};
      2'd2:    exp_d = {a_d ^ b_d, ~(a_d ^ b_d)};
      default: exp_d = {~a_d, ~b_d};
    endcase
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op1_q       <= '0;
      sel_q       <= '0;
      logic_in_q  <= '0;
      lines_q     <= '0;
      res_lo_q    <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      txn_q       <= '0;
`ifdef LOGIC_DRIVER_SELF_CHECK_EN
      chk_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_valid) begin
            op1_q   <= bus.op_data;
            sel_q   <= bus.op_sel;
            state_q <= OP2;
          end
        end
        OP2: begin
          if (bus.op_valid) begin
            logic_in_q <= {op1_q, bus.op_data};
            lines_q    <= sel_q;
            op_ready_q <= 1'b0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          // Upper half goes straight to the output register; only the low half needs holding.
          res_data_q  <= logic_out[31:16];
          res_lo_q    <= logic_out[15:0];
          res_valid_q <= 1'b1;
          state_q     <= SEND_HI;
`ifdef LOGIC_DRIVER_SELF_CHECK_EN
          if (logic_out != exp_d) chk_q <= 1'b1;
`endif
        end
        SEND_HI: begin
          if (bus.res_ready) begin
            res_data_q <= res_lo_q;
            state_q    <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_ready_q  <= 1'b1;
            txn_q       <= txn_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.op_ready  = op_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign logic_in      = logic_in_q;
  assign logic_lines   = lines_q;
  assign txn_count     = txn_q;

endmodule

// File: tb/tb_logic_driver.sv
// Self-checking bench for logic_driver with a behavioural logic unit and a result-beat scoreboard.
module tb_logic_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] logic_in;
  logic [1:0]  logic_lines;
  logic [31:0] logic_out;
  logic [7:0]  txn_count;
  logic        chk_err;
  logic        force_zero = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_txn = 8'd0;

  logic_driver_if bus();

  always #5 clk = ~clk;

  logic_driver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .logic_in    (logic_in),
    .logic_lines (logic_lines),
    .logic_out   (logic_out),
    .txn_count   (txn_count),
    .chk_err     (chk_err)
  );

  function automatic logic [31:0] lu(input logic [31:0] packed_in, input logic [1:0] s);
    logic [15:0] x;
    logic [15:0] y;
    x = packed_in[31:16];
    y = packed_in[15:0];
    case (s)
      2'd0:    return {x & y, ~(x & y)};
      2'd1:    return {x | y, ~(x | y)};
      2'd2:    return {x ^ y, ~(x ^ y)};
      default: return {~x, ~y};
    endcase
  endfunction

  assign logic_out = force_zero ? 32'h0 : lu(logic_in, logic_lines);

  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [1:0]  sel;
    logic [15:0] hi;
    logic [15:0] lo;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_beat unexpected actual=%h required=none", bus.res_data);
      end else begin
        chk("res_beat", 32'(bus.res_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (!bus.op_ready && n < max) begin
      step();
      n++;
    end
    chk("op_ready_timeout", 32'(bus.op_ready), 32'd1);
  endtask

  task automatic wait_res_valid(input int max);
    int n = 0;
    while (!bus.res_valid && n < max) begin
      step();
      n++;
    end
    chk("res_valid_timeout", 32'(bus.res_valid), 32'd1);
  endtask

  task automatic send_ops(input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] s1, input logic [1:0] s2);
    wait_ready(20);
    bus.op_valid = 1'b1;
    bus.op_data  = a;
    bus.op_sel   = s1;
    step();
    bus.op_data  = b;
    bus.op_sel   = s2;
    step();
    bus.op_valid = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_op_ready",    32'(bus.op_ready),  32'd1);
    chk("rst_res_valid",   32'(bus.res_valid), 32'd0);
    chk("rst_res_data",    32'(bus.res_data),  32'd0);
    chk("rst_logic_in",    logic_in,           32'd0);
    chk("rst_logic_lines", 32'(logic_lines),   32'd0);
    chk("rst_txn_count",   32'(txn_count),     32'd0);
    chk("rst_chk_err",     32'(chk_err),       32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back(v.hi);
    exp_q.push_back(v.lo);
    send_ops(v.op1, v.op2, v.sel, v.sel);
    chk("logic_in",    logic_in,         {v.op1, v.op2});
    chk("logic_lines", 32'(logic_lines), 32'(v.sel));
    chk("issue_op_ready", 32'(bus.op_ready), 32'd0);
    wait_ready(10);
    exp_txn = exp_txn + 8'd1;
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
  endtask

  logic chk_exp;

  initial begin
    vecs[0] = '{16'hF0F0, 16'hFF00, 2'd0, 16'hF000, 16'h0FFF};
    vecs[1] = '{16'hF0F0, 16'hFF00, 2'd1, 16'hFFF0, 16'h000F};
    vecs[2] = '{16'hF0F0, 16'hFF00, 2'd2, 16'h0FF0, 16'hF00F};
    vecs[3] = '{16'hF0F0, 16'hFF00, 2'd3, 16'h0F0F, 16'h00FF};
    vecs[4] = '{16'h1234, 16'h5678, 2'd2, 16'h444C, 16'hBBB3};
    vecs[5] = '{16'hFFFF, 16'h0000, 2'd0, 16'h0000, 16'hFFFF};

`ifdef LOGIC_DRIVER_SELF_CHECK_EN
    chk_exp = 1'b1;
`else
    chk_exp = 1'b0;
`endif

    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.op_sel    = '0;
    bus.res_ready = 1'b1;

    #2 rst_n = 1'b0;
    #3 check_reset();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Table vectors, back-to-back with the result stream always ready.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Result stream stalled in SEND_HI.
    bus.res_ready = 1'b0;
    exp_q.push_back(16'hF000);
    exp_q.push_back(16'h0FFF);
    send_ops(16'hF0F0, 16'hFF00, 2'd0, 2'd0);
    wait_res_valid(10);
    for (int i = 0; i < 4; i++) begin
      chk("stall_res_data", 32'(bus.res_data), 32'h0000F000);
      chk("stall_op_ready", 32'(bus.op_ready), 32'd0);
      step();
    end
    bus.res_ready = 1'b1;
    wait_ready(10);
    exp_txn = exp_txn + 8'd1;
    chk("stall_txn_count", 32'(txn_count), 32'(exp_txn));

    // Select on the op2 beat is ignored.
    exp_q.push_back(16'hF000);
    exp_q.push_back(16'h0FFF);
    send_ops(16'hF0F0, 16'hFF00, 2'd0, 2'd3);
    chk("op2_sel_ignored", 32'(logic_lines), 32'd0);
    wait_ready(10);
    exp_txn = exp_txn + 8'd1;
    chk("sel_txn_count", 32'(txn_count), 32'(exp_txn));
    chk("chk_err_clean", 32'(chk_err), 32'd0);

    // Broken logic unit: checker flags it only when enabled, and the flag is sticky.
    force_zero = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    send_ops(16'hFFFF, 16'hFFFF, 2'd0, 2'd0);
    wait_ready(10);
    force_zero = 1'b0;
    exp_txn = exp_txn + 8'd1;
    chk("chk_err_set", 32'(chk_err), 32'(chk_exp));
    run_vec(vecs[1]);
    chk("chk_err_sticky", 32'(chk_err), 32'(chk_exp));

    // Asynchronous reset while in SEND_LO.
    bus.res_ready = 1'b0;
    exp_q.push_back(16'hF000);
    send_ops(16'hF0F0, 16'hFF00, 2'd0, 2'd0);
    wait_res_valid(10);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("send_lo_data", 32'(bus.res_data), 32'h00000FFF);
    #2 rst_n = 1'b0;
    #1 check_reset();
    exp_q.delete();
    exp_txn = 8'd0;
    @(negedge clk) rst_n = 1'b1;
    bus.res_ready = 1'b1;
    step();
    run_vec(vecs[0]);

    // Random traffic through the 255 -> 0 wrap of txn_count.
    for (int i = 0; i < 255; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  s;
      logic [31:0] e;
      a = 16'($urandom);
      b = 16'($urandom);
      s = 2'($urandom_range(0, 3));
      e = lu({a, b}, s);
      exp_q.push_back(e[31:16]);
      exp_q.push_back(e[15:0]);
      send_ops(a, b, s, 2'($urandom_range(0, 3)));
      wait_ready(10);
      exp_txn = exp_txn + 8'd1;
      chk("wrap_txn_count", 32'(txn_count), 32'(exp_txn));
    end
    chk("wrap_to_zero", 32'(txn_count), 32'd0);

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
